// File: rtl/mmio_arb_pkg.sv
// -----------------------------------------------------------------------------
// mmio_arb_pkg
// Shared definitions for the MMIO bus arbiter slice: io-map widths, the
// arbiter state type, the latched request record and the error read pattern.
// Imported by mmio_rr_arbiter and mmio_bus_arbiter.
// -----------------------------------------------------------------------------
package mmio_arb_pkg;

    // Widths of the MMIO io-map: word address, data, register-in-slot,
    // slot select, number of slot strobe lines and how many are populated.
    localparam int MMIO_ADDR_WIDTH = 21;
    localparam int DATA_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int SLOT_ADDR_WIDTH = 6;
    localparam int NUM_SLOTS       = 64;
    localparam int NUM_USED_SLOTS  = 4;

    // Read data returned for an access to an unpopulated slot when the
    // error feature is compiled in.
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Transaction sequencer: accept in IDLE, strobe in ACCESS, answer in RESP.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Everything about the granted request that must survive past the
    // handshake cycle.
    typedef struct packed {
        logic                       wr;
        logic [SLOT_ADDR_WIDTH-1:0] slot;
        logic [REG_ADDR_WIDTH-1:0]  regAddr;
        logic [DATA_WIDTH-1:0]      wdata;
    } mmio_req_t;

    // One-hot expansion of a slot number onto the strobe lines.
    function automatic logic [NUM_SLOTS-1:0] slotOneHot(input logic [SLOT_ADDR_WIDTH-1:0] slot);
        logic [NUM_SLOTS-1:0] oh;
        oh       = '0;
        oh[slot] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mmio_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_rr_arbiter
// Two-way round-robin grant. The winner of a tie is the master that was not
// granted last; the history only advances when the grant is actually taken.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   req_i[1:0]    request lines, bit X = master X
//   accept_i      the current grant is being consumed this cycle
//   grant_o       id of the granted master (valid when grantValid_o)
//   grantValid_o  at least one master is requesting
// -----------------------------------------------------------------------------
module mmio_rr_arbiter
    import mmio_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       grant_o,
    output logic       grantValid_o
);

    logic lastGrant_q;
    logic lastGrant_d;

    // A lone requester always wins; on a tie the master that did not get the
    // previous grant goes first. The history only moves when the grant is
    // taken so a master that is waiting never loses its turn.
    always_comb begin
        grantValid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~lastGrant_q;
        end else begin
            grant_o = req_i[1];
        end
        lastGrant_d = accept_i ? grant_o : lastGrant_q;
    end

    // History starts at master 1 so master 0 wins the first tie after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_bus_arbiter
// Shares the MMIO slot bus between m0 (MicroBlaze MCS bridge) and m1 (UART
// debug master). One transaction at a time: accept at T, registered one-hot
// slot strobes at T+1, response pulse with read data at T+2, next accept at
// T+3 at the earliest.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mX_req_valid/ready      request handshake (ready is combinational)
//   mX_req_wr/addr/wdata    request payload; addr[10:5]=slot, addr[4:0]=reg
//   mX_rsp_valid/rdata/err  one-cycle response to the granted master
//   slot_cs/rd/wr           one-hot slot strobes, asserted for one cycle
//   slot_reg_addr           register address broadcast to all slots
//   slot_wr_data            write data broadcast to all slots
//   slot_rd_data            flattened read data, slot k at [k*DW +: DW]
//
// Build option:
//   MMIO_BUS_ERR_EN  slots >= USED_SLOTS are rejected: no strobes, the
//                    response carries rsp_err=1 and ERR_RDATA. Without it
//                    rsp_err stays 0 and every slot is accessed normally.
// -----------------------------------------------------------------------------
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int MMIO_AW    = MMIO_ADDR_WIDTH,
    parameter int DW         = DATA_WIDTH,
    parameter int RAW        = REG_ADDR_WIDTH,
    parameter int SAW        = SLOT_ADDR_WIDTH,
    parameter int NSLOT      = NUM_SLOTS,
    parameter int USED_SLOTS = NUM_USED_SLOTS
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic                m0_req_wr,
    input  logic [MMIO_AW-1:0]  m0_req_addr,
    input  logic [DW-1:0]       m0_req_wdata,
    output logic                m0_rsp_valid,
    output logic [DW-1:0]       m0_rsp_rdata,
    output logic                m0_rsp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic                m1_req_wr,
    input  logic [MMIO_AW-1:0]  m1_req_addr,
    input  logic [DW-1:0]       m1_req_wdata,
    output logic                m1_rsp_valid,
    output logic [DW-1:0]       m1_rsp_rdata,
    output logic                m1_rsp_err,

    output logic [NSLOT-1:0]    slot_cs,
    output logic [NSLOT-1:0]    slot_rd,
    output logic [NSLOT-1:0]    slot_wr,
    output logic [RAW-1:0]      slot_reg_addr,
    output logic [DW-1:0]       slot_wr_data,
    input  logic [NSLOT*DW-1:0] slot_rd_data
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    mmio_req_t          req_q;
    mmio_req_t          newReq;
    logic               grantId_q;
    logic               err_q;
    logic               grantId;
    logic               grantValid;
    logic               acceptReq;
    logic               newErr;
    logic [MMIO_AW-1:0] selAddr;
    logic [NSLOT-1:0]   newOneHot;
    logic [NSLOT-1:0]   slotCs_q;
    logic [NSLOT-1:0]   slotRd_q;
    logic [NSLOT-1:0]   slotWr_q;
    logic [RAW-1:0]     slotRegAddr_q;
    logic [DW-1:0]      slotWrData_q;
    logic [DW-1:0]      rdata_q;
    logic [1:0]         rspValid_q;
    logic               rspErr_q;

    mmio_rr_arbiter u_rr (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .req_i        ({m1_req_valid, m0_req_valid}),
        .accept_i     (acceptReq),
        .grant_o      (grantId),
        .grantValid_o (grantValid)
    );

    // A request is taken only in IDLE. reset_n is folded in because ready is
    // combinational and must read 0 the instant reset is asserted, even
    // though the state register already sits in IDLE.
    always_comb begin
        acceptReq    = reset_n & (state_q == ST_IDLE) & grantValid;
        m0_req_ready = acceptReq & ~grantId;
        m1_req_ready = acceptReq &  grantId;
    end

    // Steer the granted master's payload and slice the address into slot and
    // register fields; address bits above the slot field are don't-care.
    always_comb begin
        selAddr        = grantId ? m1_req_addr : m0_req_addr;
        newReq.wr      = grantId ? m1_req_wr : m0_req_wr;
        newReq.wdata   = grantId ? m1_req_wdata : m0_req_wdata;
        newReq.slot    = selAddr[RAW +: SAW];
        newReq.regAddr = selAddr[RAW-1:0];
        newOneHot      = slotOneHot(newReq.slot);
    end

    // Unpopulated slots are only flagged when the error feature is built in.
`ifdef MMIO_BUS_ERR_EN
    assign newErr = (32'(newReq.slot) >= USED_SLOTS);
`else
    assign newErr = 1'b0;
`endif

    // Fixed three-step sequence; ACCESS and RESP each last exactly one cycle.
    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE:   state_d = acceptReq ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state plus the request record captured at the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            grantId_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acceptReq) begin
                req_q     <= newReq;
                grantId_q <= grantId;
                err_q     <= newErr;
            end
        end
    end

    // Strobes are loaded on the accept edge and cleared on the next one, so
    // they are high for exactly the ACCESS cycle. Register address and write
    // data are loaded on accept and simply held until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slotCs_q      <= '0;
            slotRd_q      <= '0;
            slotWr_q      <= '0;
            slotRegAddr_q <= '0;
            slotWrData_q  <= '0;
        end else begin
            if (acceptReq && !newErr) begin
                slotCs_q <= newOneHot;
                slotRd_q <= newReq.wr ? '0 : newOneHot;
                slotWr_q <= newReq.wr ? newOneHot : '0;
            end else begin
                slotCs_q <= '0;
                slotRd_q <= '0;
                slotWr_q <= '0;
            end
            if (acceptReq) begin
                slotRegAddr_q <= newReq.regAddr;
                slotWrData_q  <= newReq.wdata;
            end
        end
    end

    // The read data of the addressed slot is sampled on the edge that closes
    // ACCESS, which is also the edge that raises the response pulse. Writes
    // return zero and rejected accesses return the error pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q    <= '0;
            rspValid_q <= '0;
            rspErr_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            if (err_q) begin
                rdata_q <= ERR_RDATA;
            end else if (req_q.wr) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= slot_rd_data[32'(req_q.slot) * DW +: DW];
            end
            rspValid_q <= {grantId_q, ~grantId_q};
            rspErr_q   <= err_q;
        end else begin
            rspValid_q <= '0;
            rspErr_q   <= 1'b0;
        end
    end

    assign m0_rsp_valid  = rspValid_q[0];
    assign m1_rsp_valid  = rspValid_q[1];
    assign m0_rsp_err    = rspErr_q & rspValid_q[0];
    assign m1_rsp_err    = rspErr_q & rspValid_q[1];
    assign m0_rsp_rdata  = rdata_q;
    assign m1_rsp_rdata  = rdata_q;
    assign slot_cs       = slotCs_q;
    assign slot_rd       = slotRd_q;
    assign slot_wr       = slotWr_q;
    assign slot_reg_addr = slotRegAddr_q;
    assign slot_wr_data  = slotWrData_q;

endmodule
